vga_scan_ctrl: RTL and testbench

Parametrised VGA scan controller that replaces the fixed 640x480 timing block in the SRAM-to-VGA path. It derives a pixel-rate strobe from the system clock, generates HSYNC/VSYNC/DE with configurable porch, sync and polarity settings, and issues linear frame-buffer read addresses for a configurable display window. It re-aligns the returned pixel data with the sync signals using a parametrised read-latency pipeline. It sits between the SRAM read port and the DAC/RGB pins.

---
 rtl/vga_scan_ctrl_if.sv | 22 ++
 rtl/vga_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_ctrl_if.sv
// Frame-buffer read port between the VGA scan controller and the SRAM.
// The controller drives the request and address; the memory side returns
// pixel data a fixed number of pixel ticks later.
interface vga_scan_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              RD_REQ;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [2:0]        RD_DATA;

    modport master (
        output RD_REQ,
        output RD_ADDR,
        input  RD_DATA
    );

    modport slave (
        input  RD_REQ,
        input  RD_ADDR,
        output RD_DATA
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller.
// A pixel strobe is divided down from CLK. Raster counters produce the syncs,
// the active-video flag and linear frame-buffer read addresses for a window.
// Because SRAM data comes back PIPE pixel ticks after its request, the syncs,
// DE and the colour-select flags ride a PIPE-deep delay line. This keeps
// everything on the RGB pins aligned with the data that actually arrived.
module vga_scan_ctrl #(
    parameter int       CLK_DIV      = 5,
    parameter int       H_SYNC       = 96,
    parameter int       H_BP         = 48,
    parameter int       H_ACT        = 640,
    parameter int       H_FP         = 16,
    parameter int       V_SYNC       = 2,
    parameter int       V_BP         = 33,
    parameter int       V_ACT        = 480,
    parameter int       V_FP         = 10,
    parameter bit       SYNC_ACT_LOW = 1'b1,
    parameter int       WIN_X0       = 0,
    parameter int       WIN_Y0       = 0,
    parameter int       WIN_W        = 640,
    parameter int       WIN_H        = 240,
    parameter logic [2:0] BG_COLOR   = 3'b000,
    parameter int       ADDR_W       = 18,
    parameter int       PIPE         = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    vga_scan_ctrl_if.master   rd,
    output logic              PIX_EN,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DE,
    output logic [9:0]        X,
    output logic [9:0]        Y,
    output logic              FRAME_START,
    output logic [2:0]        RGB_Sig
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_A0    = H_SYNC + H_BP;
    localparam int H_A1    = H_A0 + H_ACT;
    localparam int V_A0    = V_SYNC + V_BP;
    localparam int V_A1    = V_A0 + V_ACT;
    // The window is clipped to the active area so it never addresses blanking.
    localparam int WX1     = (WIN_X0 + WIN_W < H_ACT) ? WIN_X0 + WIN_W : H_ACT;
    localparam int WY1     = (WIN_Y0 + WIN_H < V_ACT) ? WIN_Y0 + WIN_H : V_ACT;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam logic SYNC_INV = SYNC_ACT_LOW;

    logic [DW-1:0]     dcnt;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [ADDR_W-1:0] row_base;

    logic              tick;
    logic              h_last;
    logic              v_last;
    logic              at_origin;
    logic              hs_raw;
    logic              vs_raw;
    logic              h_act;
    logic              v_act;
    logic              act;
    logic              win;
    logic              win_last;
    logic [9:0]        x_c;
    logic [9:0]        y_c;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [ADDR_W-1:0] addr_c;

    logic [PIPE-1:0]   p_hs;
    logic [PIPE-1:0]   p_vs;
    logic [PIPE-1:0]   p_de;
    logic [PIPE-1:0]   p_win;

    // Decode the raster position into sync, active, window and address terms
    always_comb begin
        tick      = EN && (dcnt == DW'(CLK_DIV - 1));
        h_last    = (hcnt == HW'(H_TOTAL - 1));
        v_last    = (vcnt == VW'(V_TOTAL - 1));
        at_origin = (hcnt == '0) && (vcnt == '0);
        hs_raw    = (hcnt < HW'(H_SYNC));
        vs_raw    = (vcnt < VW'(V_SYNC));
        h_act     = (hcnt >= HW'(H_A0)) && (hcnt < HW'(H_A1));
        v_act     = (vcnt >= VW'(V_A0)) && (vcnt < VW'(V_A1));
        act       = h_act && v_act;
        x_c       = '0;
        y_c       = '0;
        if (act) begin
            x_c = 10'(hcnt - HW'(H_A0));
            y_c = 10'(vcnt - VW'(V_A0));
        end
        // Offsets into the window; bit 10 set means left of / above the window.
        dx       = {1'b0, x_c} - 11'(WIN_X0);
        dy       = {1'b0, y_c} - 11'(WIN_Y0);
        win      = act && !dx[10] && (dx[9:0] < 10'(WX1 - WIN_X0))
                       && !dy[10] && (dy[9:0] < 10'(WY1 - WIN_Y0));
        win_last = win && (dx[9:0] == 10'(WX1 - WIN_X0 - 1));
        addr_c   = row_base + ADDR_W'(dx[9:0]);
    end

    // Pixel divider, raster counters, row base and the request-side outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dcnt        <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            row_base    <= '0;
            PIX_EN      <= 1'b0;
            FRAME_START <= 1'b0;
            rd.RD_REQ   <= 1'b0;
            rd.RD_ADDR  <= '0;
            X           <= '0;
            Y           <= '0;
        end else if (!EN) begin
            dcnt        <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            row_base    <= '0;
            PIX_EN      <= 1'b0;
            FRAME_START <= 1'b0;
            rd.RD_REQ   <= 1'b0;
            rd.RD_ADDR  <= '0;
            X           <= '0;
            Y           <= '0;
        end else begin
            PIX_EN      <= tick;
            FRAME_START <= tick && at_origin;
            dcnt        <= tick ? '0 : dcnt + 1'b1;
            if (tick) begin
                hcnt <= h_last ? '0 : hcnt + 1'b1;
                if (h_last) begin
                    vcnt <= v_last ? '0 : vcnt + 1'b1;
                end
                // Clearing on the wrap tick guarantees the new frame starts at address 0.
                if (h_last && v_last) begin
                    row_base <= '0;
                end else if (win_last) begin
                    row_base <= row_base + ADDR_W'(WIN_W);
                end
                rd.RD_REQ  <= win;
                rd.RD_ADDR <= win ? addr_c : '0;
                X          <= x_c;
                Y          <= y_c;
            end
        end
    end

    // Delay syncs and select flags by the read latency, then pick the pixel colour
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p_hs    <= '0;
            p_vs    <= '0;
            p_de    <= '0;
            p_win   <= '0;
            HSYNC   <= SYNC_INV;
            VSYNC   <= SYNC_INV;
            DE      <= 1'b0;
            RGB_Sig <= 3'b000;
        end else if (!EN) begin
            p_hs    <= '0;
            p_vs    <= '0;
            p_de    <= '0;
            p_win   <= '0;
            HSYNC   <= SYNC_INV;
            VSYNC   <= SYNC_INV;
            DE      <= 1'b0;
            RGB_Sig <= 3'b000;
        end else if (tick) begin
            p_hs[0]  <= hs_raw;
            p_vs[0]  <= vs_raw;
            p_de[0]  <= act;
            p_win[0] <= win;
            for (int i = 1; i < PIPE; i++) begin
                p_hs[i]  <= p_hs[i-1];
                p_vs[i]  <= p_vs[i-1];
                p_de[i]  <= p_de[i-1];
                p_win[i] <= p_win[i-1];
            end
            HSYNC   <= p_hs[PIPE-1] ^ SYNC_INV;
            VSYNC   <= p_vs[PIPE-1] ^ SYNC_INV;
            DE      <= p_de[PIPE-1];
            RGB_Sig <= p_win[PIPE-1] ? rd.RD_DATA
                     : (p_de[PIPE-1] ? BG_COLOR : 3'b000);
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using two small raster configurations.
// Instance A: CLK_DIV=3, H 4/3/10/2, V 2/2/6/1, active-low syncs, window at (2,1)
// that is 5x3, BG=101, PIPE=2, and constant read data 010.
// Instance B: CLK_DIV=1, H 2/2/8/2, V 1/1/4/1, active-high syncs, window covering
// the full active area, PIPE=3. Its memory returns RD_ADDR[2:0] three ticks later.
module tb_vga_scan_ctrl;

    logic CLK = 1'b0;
    logic RSTn;
    logic en_a, en_b;

    logic       pix_en_a, hsync_a, vsync_a, de_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [2:0] rgb_a;
    logic       pix_en_b, hsync_b, vsync_b, de_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [2:0] rgb_b;
    logic [2:0] mem_b0, mem_b1;

    int cyc, ba, bb;
    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    vga_scan_ctrl_if #(.ADDR_W(8)) rd_a ();
    vga_scan_ctrl_if #(.ADDR_W(6)) rd_b ();

    vga_scan_ctrl #(
        .CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_ACT(10), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1), .SYNC_ACT_LOW(1'b1),
        .WIN_X0(2), .WIN_Y0(1), .WIN_W(5), .WIN_H(3), .BG_COLOR(3'b101),
        .ADDR_W(8), .PIPE(2)
    ) dut_a (
        .CLK(CLK), .RSTn(RSTn), .EN(en_a), .rd(rd_a),
        .PIX_EN(pix_en_a), .HSYNC(hsync_a), .VSYNC(vsync_a), .DE(de_a),
        .X(x_a), .Y(y_a), .FRAME_START(fs_a), .RGB_Sig(rgb_a)
    );

    vga_scan_ctrl #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .SYNC_ACT_LOW(1'b0),
        .WIN_X0(0), .WIN_Y0(0), .WIN_W(8), .WIN_H(4), .BG_COLOR(3'b000),
        .ADDR_W(6), .PIPE(3)
    ) dut_b (
        .CLK(CLK), .RSTn(RSTn), .EN(en_b), .rd(rd_b),
        .PIX_EN(pix_en_b), .HSYNC(hsync_b), .VSYNC(vsync_b), .DE(de_b),
        .X(x_b), .Y(y_b), .FRAME_START(fs_b), .RGB_Sig(rgb_b)
    );

    assign rd_a.RD_DATA = 3'b010;

    // Memory for B: two registers plus the DUT capture edge give three ticks of latency
    always @(posedge CLK) begin
        mem_b0 <= rd_b.RD_ADDR[2:0];
        mem_b1 <= mem_b0;
    end
    assign rd_b.RD_DATA = mem_b1;

    // System clock
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic goto_a(input int k);
        goto(ba + 3 * (k + 1));
    endtask

    // Directed stimulus and checks
    initial begin
        int  hr, vr, h, v;
        logic act_r, de_e;

        RSTn = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        cyc  = 0;
        repeat (3) @(negedge CLK);

        chk("rst_pix_en",  pix_en_a, 0);
        chk("rst_hsync_a", hsync_a, 1);
        chk("rst_vsync_a", vsync_a, 1);
        chk("rst_de",      de_a, 0);
        chk("rst_rd_req",  rd_a.RD_REQ, 0);
        chk("rst_rd_addr", rd_a.RD_ADDR, 0);
        chk("rst_x",       x_a, 0);
        chk("rst_y",       y_a, 0);
        chk("rst_fs",      fs_a, 0);
        chk("rst_rgb",     rgb_a, 0);
        chk("rst_hsync_b", hsync_b, 0);
        chk("rst_vsync_b", vsync_b, 0);

        // B: one and a half frames against a timing model; tick j lands on edge j+1
        RSTn = 1'b1;
        en_b = 1'b1;
        cyc  = 0;
        for (int j = 0; j <= 140; j++) begin
            goto(j + 1);
            hr    = j % 14;
            vr    = (j / 14) % 7;
            act_r = (hr >= 4) && (hr < 12) && (vr >= 2) && (vr < 6);
            chk("b_pix_en", pix_en_b, 1);
            chk("b_rd_req", rd_b.RD_REQ, act_r);
            chk("b_fs", fs_b, (hr == 0) && (vr == 0));
            if (act_r) begin
                chk("b_rd_addr", rd_b.RD_ADDR, 8 * (vr - 2) + (hr - 4));
                chk("b_x", x_b, hr - 4);
                chk("b_y", y_b, vr - 2);
            end
            if (j >= 3) begin
                h    = (j - 3) % 14;
                v    = ((j - 3) / 14) % 7;
                de_e = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
                chk("b_de", de_b, de_e);
                chk("b_hsync", hsync_b, h < 2);
                chk("b_vsync", vsync_b, v < 1);
                chk("b_rgb", rgb_b, de_e ? (h - 4) : 0);
            end else begin
                chk("b_de_flush", de_b, 0);
                chk("b_hsync_flush", hsync_b, 0);
                chk("b_rgb_flush", rgb_b, 0);
            end
        end

        // B: drop EN mid-frame for 100 CLK, then re-enable
        goto(141);
        en_b = 1'b0;
        goto(142);
        chk("b_off_pix_en", pix_en_b, 0);
        chk("b_off_de", de_b, 0);
        chk("b_off_rgb", rgb_b, 0);
        chk("b_off_hsync", hsync_b, 0);
        chk("b_off_rd_req", rd_b.RD_REQ, 0);
        chk("b_off_fs", fs_b, 0);
        goto(241);
        chk("b_off_rd_addr", rd_b.RD_ADDR, 0);
        chk("b_off_vsync", vsync_b, 0);
        en_b = 1'b1;
        bb   = 242;
        goto(bb);
        chk("b_re_fs", fs_b, 1);
        chk("b_re_pix_en", pix_en_b, 1);
        goto(bb + 1);
        chk("b_re_fs_clr", fs_b, 0);
        goto(bb + 31);
        chk("b_re_req_pre", rd_b.RD_REQ, 0);
        goto(bb + 32);
        chk("b_re_req", rd_b.RD_REQ, 1);
        chk("b_re_addr", rd_b.RD_ADDR, 0);
        goto(bb + 35);
        chk("b_re_de", de_b, 1);
        chk("b_re_rgb0", rgb_b, 0);
        goto(bb + 36);
        chk("b_re_rgb1", rgb_b, 1);

        // A: start from idle; tick k lands on edge 3*(k+1)
        goto(278);
        en_b = 1'b0;
        en_a = 1'b1;
        ba   = 278;
        goto(ba + 2);
        chk("a_pix_en_pre", pix_en_a, 0);
        goto_a(0);
        chk("a_pix_en_first", pix_en_a, 1);
        chk("a_fs_first", fs_a, 1);
        chk("a_hsync_flush", hsync_a, 1);
        goto(ba + 4);
        chk("a_pix_en_clr", pix_en_a, 0);
        chk("a_fs_clr", fs_a, 0);
        goto_a(1);
        chk("a_hsync_k1", hsync_a, 1);
        goto_a(2);
        chk("a_hsync_k2", hsync_a, 0);
        chk("a_vsync_k2", vsync_a, 0);
        goto_a(5);
        chk("a_hsync_k5", hsync_a, 0);
        goto_a(6);
        chk("a_hsync_k6", hsync_a, 1);
        goto_a(39);
        chk("a_vsync_k39", vsync_a, 0);
        goto_a(40);
        chk("a_vsync_k40", vsync_a, 1);
        goto_a(103);
        chk("a_req_k103", rd_a.RD_REQ, 0);
        chk("a_x_k103", x_a, 1);
        chk("a_y_k103", y_a, 1);
        goto_a(104);
        chk("a_req_k104", rd_a.RD_REQ, 1);
        chk("a_addr_k104", rd_a.RD_ADDR, 0);
        chk("a_x_k104", x_a, 2);
        goto_a(105);
        chk("a_de_k105", de_a, 1);
        chk("a_rgb_bg", rgb_a, 3'b101);
        goto_a(106);
        chk("a_de_k106", de_a, 1);
        chk("a_rgb_win", rgb_a, 3'b010);
        goto_a(108);
        chk("a_addr_k108", rd_a.RD_ADDR, 4);
        goto_a(114);
        chk("a_de_fp", de_a, 0);
        chk("a_rgb_fp", rgb_a, 0);
        chk("a_hsync_fp", hsync_a, 1);
        goto_a(123);
        chk("a_req_k123", rd_a.RD_REQ, 1);
        chk("a_addr_k123", rd_a.RD_ADDR, 5);
        goto_a(146);
        chk("a_addr_last", rd_a.RD_ADDR, 14);
        chk("a_x_last", x_a, 6);
        chk("a_y_last", y_a, 3);
        goto_a(161);
        chk("a_req_below", rd_a.RD_REQ, 0);
        chk("a_x_below", x_a, 2);
        chk("a_y_below", y_a, 4);
        goto_a(163);
        chk("a_rgb_below", rgb_a, 3'b101);
        chk("a_de_below", de_a, 1);
        goto_a(208);
        chk("a_fs_k208", fs_a, 0);
        goto_a(209);
        chk("a_fs_wrap", fs_a, 1);
        chk("a_x_wrap", x_a, 0);
        chk("a_vsync_wrap", vsync_a, 1);
        goto(ba + 3 * 210 + 1);
        chk("a_fs_wrap_clr", fs_a, 0);
        goto_a(313);
        chk("a_req_f2", rd_a.RD_REQ, 1);
        chk("a_addr_f2", rd_a.RD_ADDR, 0);
        chk("a_de_pre_rst", de_a, 1);

        // A: asynchronous reset mid-line
        RSTn = 1'b0;
        #1;
        chk("a_arst_req", rd_a.RD_REQ, 0);
        chk("a_arst_addr", rd_a.RD_ADDR, 0);
        chk("a_arst_x", x_a, 0);
        chk("a_arst_de", de_a, 0);
        chk("a_arst_rgb", rgb_a, 0);
        chk("a_arst_hsync", hsync_a, 1);
        chk("a_arst_pix_en", pix_en_a, 0);
        goto(cyc + 2);
        RSTn = 1'b1;
        ba   = cyc;
        goto_a(0);
        chk("a_post_fs", fs_a, 1);
        chk("a_post_de0", de_a, 0);
        goto_a(1);
        chk("a_post_de1", de_a, 0);
        goto_a(2);
        chk("a_post_hsync", hsync_a, 0);
        goto_a(104);
        chk("a_post_req", rd_a.RD_REQ, 1);
        chk("a_post_addr", rd_a.RD_ADDR, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
